// File: rtl/fir_stream_ctrl.sv
// Stream controller for a 3-tap transposed-form FIR datapath: accepts samples,
// sequences the datapath load strobes, presents results and drains the tail.
module fir_stream_ctrl #(
  parameter int DATAWIDTH     = 16,
  parameter int PRODUCT_WIDTH = 2 * DATAWIDTH,
  parameter int FLUSH_TAPS    = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATAWIDTH-1:0]     in_data,
  input  logic                     in_last,
  output logic [DATAWIDTH-1:0]     dp_x,
  output logic                     ld_x,
  output logic                     ld_delay1,
  output logic                     ld_delay2,
  output logic                     ld_y,
  input  logic [PRODUCT_WIDTH-1:0] dp_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRODUCT_WIDTH-1:0] out_data,
  output logic                     out_last,
  output logic [CNT_WIDTH-1:0]     sample_count
);

  localparam int FC_W = (FLUSH_TAPS < 2) ? 1 : $clog2(FLUSH_TAPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, OUT, FLUSH} state_t;

  state_t              state, state_nxt;
  logic                last_pend, last_pend_nxt;
  logic [FC_W-1:0]     flush_cnt, flush_cnt_nxt;
  logic [CNT_WIDTH-1:0] count_q, count_nxt;

  assign out_data     = dp_y;
  assign sample_count = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_pend <= 1'b0;
      flush_cnt <= '0;
      count_q   <= '0;
    end else begin
      state     <= state_nxt;
      last_pend <= last_pend_nxt;
      flush_cnt <= flush_cnt_nxt;
      count_q   <= count_nxt;
    end
  end

  // Both streams transfer on a rising clk edge where valid && ready; the
  // result beat holds out_data stable until out_ready is seen.
  always_comb begin
    state_nxt     = state;
    last_pend_nxt = last_pend;
    flush_cnt_nxt = flush_cnt;
    count_nxt     = count_q;
    in_ready      = 1'b0;
    dp_x          = '0;
    ld_x          = 1'b0;
    ld_delay1     = 1'b0;
    ld_delay2     = 1'b0;
    ld_y          = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        dp_x     = in_data;
        if (in_valid) begin
          ld_x          = 1'b1;
          last_pend_nxt = in_last;
          if (count_q != '1) count_nxt = count_q + CNT_WIDTH'(1);
          state_nxt = CALC;
        end
      end
      CALC: begin
        ld_delay1 = 1'b1;
        ld_delay2 = 1'b1;
        ld_y      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = last_pend && (flush_cnt == FC_W'(1));
        if (out_ready) begin
          if (last_pend && flush_cnt == '0) begin
            flush_cnt_nxt = FC_W'(FLUSH_TAPS);
            state_nxt     = FLUSH;
          end else if (last_pend && flush_cnt > FC_W'(1)) begin
            flush_cnt_nxt = flush_cnt - FC_W'(1);
            state_nxt     = FLUSH;
          end else if (last_pend) begin
            last_pend_nxt = 1'b0;
            flush_cnt_nxt = '0;
            count_nxt     = '0;
            state_nxt     = IDLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        // A zero sample pushes the remaining taps out of the delay line.
        ld_x      = 1'b1;
        state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase

    if (!rst) begin
      in_ready  = 1'b0;
      dp_x      = '0;
      ld_x      = 1'b0;
      ld_delay1 = 1'b0;
      ld_delay2 = 1'b0;
      ld_y      = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a behavioural transposed-form datapath closes the
// loop, and a direct-form convolution feeds the expected-output queue.
module tb_fir_stream_ctrl;

  localparam logic signed [15:0] H0 = 16'sh0040;
  localparam logic signed [15:0] H1 = 16'sh0080;
  localparam logic signed [15:0] H2 = 16'sh0040;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [15:0] dp_x;
  logic        ld_x, ld_delay1, ld_delay2, ld_y;
  logic [31:0] dp_y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] sample_count;

  fir_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dp_x(dp_x), .ld_x(ld_x), .ld_delay1(ld_delay1), .ld_delay2(ld_delay2), .ld_y(ld_y),
    .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sample_count(sample_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // behavioural datapath
  logic signed [15:0] x_reg;
  logic signed [31:0] d1, d2, y_reg;
  assign dp_y = y_reg;
  always @(posedge clk) begin
    if (!rst) begin
      x_reg <= '0; d1 <= '0; d2 <= '0; y_reg <= '0;
    end else begin
      if (ld_x) x_reg <= dp_x;
      if (ld_y) y_reg <= d2 + 32'(x_reg) * 32'(H0);
      if (ld_delay2) d2 <= d1 + 32'(x_reg) * 32'(H1);
      if (ld_delay1) d1 <= 32'(x_reg) * 32'(H2);
    end
  end

  // scoreboard: {sample_count at last, last, data}
  logic [48:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] hist1 = '0, hist2 = '0;
  logic [15:0] frame_len = '0;
  int hs_cyc = 0, last_out_cyc = 0;
  int ldx_cnt = 0, ldy_cnt = 0, out_cnt = 0;
  bit gap_chk = 1'b0;
  int prev_ldx = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic signed [31:0] r;
    r = 32'($signed(a)) * 32'(H0) + 32'($signed(b)) * 32'(H1) + 32'($signed(c)) * 32'(H2);
    return r;
  endfunction

  task automatic push_expect(input logic [15:0] d, input logic l);
    frame_len = frame_len + 16'd1;
    exp_q.push_back({16'd0, 1'b0, conv(d, hist1, hist2)});
    hist2 = hist1; hist1 = d;
    if (l) begin
      exp_q.push_back({16'd0, 1'b0, conv(16'd0, hist1, hist2)});
      hist2 = hist1; hist1 = '0;
      exp_q.push_back({frame_len, 1'b1, conv(16'd0, hist1, hist2)});
      hist1 = '0; hist2 = '0; frame_len = '0;
    end
  endtask

  // monitor: pops one expectation per output handshake
  always @(negedge clk) begin
    if (ld_x) ldx_cnt++;
    if (ld_y) ldy_cnt++;
    if (ld_x && !in_ready) check("gated_dp_x", 64'(dp_x), 64'd0);
    if (gap_chk && ld_x) begin
      if (prev_ldx >= 0) check("ldx_gap", 64'(cyc - prev_ldx), 64'd3);
      prev_ldx = cyc;
    end
    if (rst && out_valid && out_ready) begin
      logic [48:0] ent;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL out_unexpected observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(ent[31:0]));
        check("out_last", 64'(out_last), 64'(ent[32]));
        if (ent[32]) begin
          check("count_at_last", 64'(sample_count), 64'(ent[48:33]));
          last_out_cyc = cyc;
        end
      end
      out_cnt++;
    end
  end

  // driver tasks (called at a negedge)
  task automatic send(input logic [15:0] d, input logic l);
    int budget;
    push_expect(d, l);
    in_valid = 1'b1; in_data = d; in_last = l;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("accept_timeout", 64'(budget < 100), 64'd1);
    hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int budget = 0;
    while (out_valid !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("valid_timeout", 64'(budget < 100), 64'd1);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset: outputs forced low even with a valid sample presented
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ld", 64'({ld_x, ld_delay1, ld_delay2, ld_y}), 64'd0);
    check("rst_out", 64'({out_valid, out_last}), 64'd0);
    check("rst_dp_x", 64'(dp_x), 64'd0);
    check("rst_count", 64'(sample_count), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // test 1: impulse
    ldx_cnt = 0; ldy_cnt = 0; out_cnt = 0;
    send(16'h0100, 1'b1);
    check("calc_no_valid", 64'(out_valid), 64'd0);
    wait_valid();
    check("latency", 64'(cyc - hs_cyc), 64'd2);
    drain();
    check("impulse_ldx", 64'(ldx_cnt), 64'd3);
    check("impulse_ldy", 64'(ldy_cnt), 64'd3);
    check("impulse_outs", 64'(out_cnt), 64'd3);

    // test 2: step of four samples
    out_cnt = 0;
    for (int i = 0; i < 4; i++) send(16'h0100, i == 3);
    drain();
    check("step_outs", 64'(out_cnt), 64'd6);
    check("step_count_after", 64'(sample_count), 64'd0);

    // test 3: backpressure on the first output
    out_ready = 1'b0;
    send(16'h0100, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'h4000);
      check("stall_quiet", 64'({ld_x, ld_delay1, ld_delay2, ld_y, in_ready}), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    // test 4: back-to-back frames, second accepted right after out_last
    send(16'h0100, 1'b1);
    send(16'hFF00, 1'b1);
    check("b2b_accept", 64'(hs_cyc - last_out_cyc), 64'd1);
    drain();

    // test 5: reset while stalled in OUT after two samples
    send(16'h0100, 1'b0);
    while (exp_q.size() != 0) @(negedge clk);
    out_ready = 1'b0;
    send(16'h0100, 1'b0);
    wait_valid();
    check("mid_count", 64'(sample_count), 64'd2);
    rst = 1'b0;
    exp_q.delete();
    hist1 = '0; hist2 = '0; frame_len = '0;
    @(negedge clk);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out", 64'({out_valid, out_last, ld_x, ld_delay1, ld_delay2, ld_y}), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_dp_x", 64'(dp_x), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_release_ready", 64'(in_ready), 64'd1);
    check("mid_release_count", 64'(sample_count), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    out_cnt = 0;
    send(16'h0100, 1'b1);
    drain();
    check("mid_impulse_outs", 64'(out_cnt), 64'd3);

    // test 6: in_valid held high with random samples
    gap_chk = 1'b1; prev_ldx = -1;
    for (int i = 0; i < 5; i++) send(16'($urandom_range(16'h0001, 16'hFFFF)), i == 4);
    drain();
    gap_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
